// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex tokenizer: accumulates hex digits MSB-first and emits a
// right-aligned word on each delimiter, flagging bad chars and over-long tokens.
module ascii_hex_parser #(
  parameter int unsigned DIGITS   = 8,
  parameter bit          ALLOW_LC = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     ascii_data,
  input  logic                           ascii_valid,
  output logic                           ascii_ready,
  output logic [4*DIGITS-1:0]            hex_data,
  output logic [$clog2(DIGITS+1)-1:0]    hex_ndigits,
  output logic                           hex_valid,
  input  logic                           hex_ready,
  output logic                           err_char,
  output logic                           err_ovf
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SKIP  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   acc, acc_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [DW-1:0]   hex_data_d;
  logic [CW-1:0]   hex_ndigits_d;
  logic            hex_valid_d;
  logic            err_char_d;
  logic            err_ovf_d;

  logic            is_digit;
  logic            is_delim;
  logic [3:0]      nibble;
  logic            char_acc;

  assign ascii_ready = (state != S_EMIT);
  assign char_acc    = ascii_valid & ascii_ready;

  // Character classification and nibble decode
  always_comb begin
    is_delim = (ascii_data == 8'h20) || (ascii_data == 8'h09) ||
               (ascii_data == 8'h0A) || (ascii_data == 8'h0D) ||
               (ascii_data == 8'h2C);
    is_digit = 1'b0;
    nibble   = 4'h0;
    if (ascii_data >= 8'h30 && ascii_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = 4'(ascii_data - 8'h30);
    end else if (ascii_data >= 8'h41 && ascii_data <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = 4'(ascii_data - 8'h37);
    end else if (ALLOW_LC && ascii_data >= 8'h61 && ascii_data <= 8'h66) begin
      is_digit = 1'b1;
      nibble   = 4'(ascii_data - 8'h57);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state;
    acc_d         = acc;
    cnt_d         = cnt;
    hex_data_d    = hex_data;
    hex_ndigits_d = hex_ndigits;
    hex_valid_d   = hex_valid;
    err_char_d    = 1'b0;
    err_ovf_d     = 1'b0;

    case (state)
      S_IDLE: begin
        if (char_acc) begin
          if (is_digit) begin
            acc_d   = DW'(nibble);
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end else if (!is_delim) begin
            err_char_d = 1'b1;
            state_d    = S_SKIP;
          end
        end
      end
      S_ACCUM: begin
        if (char_acc) begin
          if (is_digit) begin
            if (cnt == CW'(DIGITS)) begin
              err_ovf_d = 1'b1;
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = S_SKIP;
            end else begin
              acc_d = (acc << 4) | DW'(nibble);
              cnt_d = cnt + CW'(1);
            end
          end else if (is_delim) begin
            hex_data_d    = acc;
            hex_ndigits_d = cnt;
            hex_valid_d   = 1'b1;
            state_d       = S_EMIT;
          end else begin
            err_char_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (char_acc && is_delim) begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (hex_ready) begin
          hex_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      hex_data    <= '0;
      hex_ndigits <= '0;
      hex_valid   <= 1'b0;
      err_char    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      cnt         <= cnt_d;
      hex_data    <= hex_data_d;
      hex_ndigits <= hex_ndigits_d;
      hex_valid   <= hex_valid_d;
      err_char    <= err_char_d;
      err_ovf     <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser: default instance (8 digits, lowercase
// allowed) plus a narrow uppercase-only instance (2 digits).
module tb_ascii_hex_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a1_data;
  logic        a1_valid, a1_ready;
  logic [31:0] h1_data;
  logic [3:0]  h1_nd;
  logic        h1_valid, h1_ready, e1c, e1o;

  logic [7:0]  a2_data;
  logic        a2_valid, a2_ready;
  logic [7:0]  h2_data;
  logic [1:0]  h2_nd;
  logic        h2_valid, h2_ready, e2c, e2o;

  ascii_hex_parser #(.DIGITS(8), .ALLOW_LC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ascii_data(a1_data), .ascii_valid(a1_valid),
    .ascii_ready(a1_ready), .hex_data(h1_data), .hex_ndigits(h1_nd),
    .hex_valid(h1_valid), .hex_ready(h1_ready), .err_char(e1c), .err_ovf(e1o));

  ascii_hex_parser #(.DIGITS(2), .ALLOW_LC(1'b0)) dut2 (
    .clk(clk), .rst(rst), .ascii_data(a2_data), .ascii_valid(a2_valid),
    .ascii_ready(a2_ready), .hex_data(h2_data), .hex_ndigits(h2_nd),
    .hex_valid(h2_valid), .hex_ready(h2_ready), .err_char(e2c), .err_ovf(e2o));

  int total = 0;
  int bad   = 0;

  logic [31:0] w1q[$];
  int          n1q[$];
  int          c1 = 0, o1 = 0;
  logic [7:0]  w2q[$];
  int          n2q[$];
  int          c2 = 0, o2 = 0;

  // Collect accepted words and error pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (h1_valid && h1_ready) begin
        w1q.push_back(h1_data);
        n1q.push_back(int'(h1_nd));
      end
      if (e1c) c1++;
      if (e1o) o1++;
      if (h2_valid && h2_ready) begin
        w2q.push_back(h2_data);
        n2q.push_back(int'(h2_nd));
      end
      if (e2c) c2++;
      if (e2o) o2++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    w1q.delete(); n1q.delete(); c1 = 0; o1 = 0;
    w2q.delete(); n2q.delete(); c2 = 0; o2 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input byte c);
    int n = 0;
    a1_data  = c;
    a1_valid = 1'b1;
    while (!a1_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("send1_timeout", 64'(a1_ready), 64'd1);
    @(posedge clk); #1;
    a1_valid = 1'b0;
    a1_data  = 8'h00;
  endtask

  task automatic send2(input byte c);
    int n = 0;
    a2_data  = c;
    a2_valid = 1'b1;
    while (!a2_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("send2_timeout", 64'(a2_ready), 64'd1);
    @(posedge clk); #1;
    a2_valid = 1'b0;
    a2_data  = 8'h00;
  endtask

  task automatic str1(input string s);
    for (int i = 0; i < s.len(); i++) send1(s[i]);
  endtask

  task automatic str2(input string s);
    for (int i = 0; i < s.len(); i++) send2(s[i]);
  endtask

  task automatic check_word1(input string tag, input logic [31:0] d, input int nd);
    check({tag, "_count"}, 64'(w1q.size()), 64'd1);
    if (w1q.size() > 0) begin
      check({tag, "_data"}, 64'(w1q[0]), 64'(d));
      check({tag, "_nd"}, 64'(n1q[0]), 64'(nd));
    end
  endtask

  initial begin
    rst = 1'b1;
    a1_data = 8'h00; a1_valid = 1'b0; h1_ready = 1'b1;
    a2_data = 8'h00; a2_valid = 1'b0; h2_ready = 1'b1;
    idle(2);

    // Reset state
    check("rst_ready", 64'(a1_ready), 64'd1);
    check("rst_valid", 64'(h1_valid), 64'd0);
    check("rst_data", 64'(h1_data), 64'd0);
    check("rst_nd", 64'(h1_nd), 64'd0);
    check("rst_errs", 64'({e1c, e1o, e2c, e2o}), 64'd0);
    rst = 1'b0;
    idle(1);
    clear_mon();

    // Mixed-case word
    str1("1A2f\n");
    idle(3);
    check_word1("t1", 32'h00001A2F, 4);
    check("t1_errs", 64'(c1 + o1), 64'd0);
    clear_mon();

    // Overflow on the ninth digit, then a short word
    str1("12345678");
    send1("9");
    check("t2_ovf_pulse", 64'(e1o), 64'd1);
    check("t2_char_quiet", 64'(e1c), 64'd0);
    str1(" 5 ");
    idle(3);
    check_word1("t2", 32'h5, 1);
    check("t2_ovf_once", 64'(o1), 64'd1);
    check("t2_char_none", 64'(c1), 64'd0);
    clear_mon();

    // Invalid char skips rest of token; empty tokens ignored
    send1("1");
    send1("G");
    check("t3_char_pulse", 64'(e1c), 64'd1);
    str1("3,,7\r");
    idle(3);
    check_word1("t3", 32'h7, 1);
    check("t3_char_once", 64'(c1), 64'd1);
    check("t3_ovf_none", 64'(o1), 64'd0);
    clear_mon();

    // Backpressure holds word stable and blocks input
    h1_ready = 1'b0;
    str1("ABCD ");
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(h1_valid), 64'd1);
      check("t4_hold_data", 64'(h1_data), 64'h0000ABCD);
      check("t4_hold_ready", 64'(a1_ready), 64'd0);
      idle(1);
    end
    h1_ready = 1'b1;
    idle(1);
    check("t4_ready_after", 64'(a1_ready), 64'd1);
    check("t4_valid_after", 64'(h1_valid), 64'd0);
    check_word1("t4", 32'h0000ABCD, 4);
    clear_mon();

    // Exactly DIGITS digits is legal
    str1("FFFFFFFF ");
    idle(3);
    check_word1("full", 32'hFFFFFFFF, 8);
    check("full_ovf_none", 64'(o1), 64'd0);
    clear_mon();

    // Async reset mid-token drops partial word
    str1("12");
    rst = 1'b1;
    #1;
    check("t6a_ready", 64'(a1_ready), 64'd1);
    check("t6a_data", 64'(h1_data), 64'd0);
    check("t6a_outs", 64'({h1_valid, h1_nd, e1c, e1o}), 64'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    clear_mon();
    str1("3 ");
    idle(3);
    check_word1("t6a", 32'h3, 1);
    clear_mon();

    // Async reset while a word is pending
    h1_ready = 1'b0;
    str1("45 ");
    check("t6b_pending", 64'(h1_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6b_valid", 64'(h1_valid), 64'd0);
    check("t6b_ready", 64'(a1_ready), 64'd1);
    check("t6b_data", 64'({h1_data, h1_nd}), 64'd0);
    idle(1);
    rst = 1'b0;
    h1_ready = 1'b1;
    idle(1);
    clear_mon();
    str1("3 ");
    idle(3);
    check_word1("t6b", 32'h3, 1);
    check("t6b_errs", 64'(c1 + o1), 64'd0);
    clear_mon();

    // Narrow uppercase-only instance
    send2("f");
    check("t5_lc_pulse", 64'(e2c), 64'd1);
    str2("f ");
    idle(3);
    check("t5_lc_noword", 64'(w2q.size()), 64'd0);
    check("t5_lc_once", 64'(c2), 64'd1);
    clear_mon();
    str2("FF ");
    idle(3);
    check("t5_ff_count", 64'(w2q.size()), 64'd1);
    if (w2q.size() > 0) begin
      check("t5_ff_data", 64'(w2q[0]), 64'hFF);
      check("t5_ff_nd", 64'(n2q[0]), 64'd2);
    end
    clear_mon();
    str2("FF");
    send2("F");
    check("t5_ovf_pulse", 64'(e2o), 64'd1);
    send2(" ");
    idle(3);
    check("t5_ovf_noword", 64'(w2q.size()), 64'd0);
    check("t5_ovf_once", 64'(o2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
